// File: rtl/regwb_pkg.sv
// regwb_pkg: shared constants and the write-back entry type
// for the register-file write-back arbiter.
package regwb_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] SP_IDX = 5'd31;
    localparam int WB_DATA_W = 64;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regwb_fifo.sv
// regwb_fifo: per-source synchronous FIFO holding {rd, data} entries.
// Ports: clk, reset_n, push_i/data_i (write), pop_i (read),
// full_o, empty_o, head_o (oldest entry, valid when !empty_o).
module regwb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 69
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/regwb_arbiter.sv
// regwb_arbiter: round-robin write-back arbiter feeding the single
// register-file write port from NUM_SRC per-source FIFOs.
// Ports: clk, reset_n; per source src_valid/src_ready/src_rd/
// src_to_sp/src_data; to the register file RegWrite,
// Write_register, Write_d; status busy and xzr_drop.
module regwb_arbiter
    import regwb_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [NUM_SRC-1:0]           src_ready,
    input  logic [NUM_SRC*REG_IDX_W-1:0] src_rd,
    input  logic [NUM_SRC-1:0]           src_to_sp,
    input  logic [NUM_SRC*DATA_W-1:0]    src_data,
    output logic                         RegWrite,
    output logic [REG_IDX_W-1:0]         Write_register,
    output logic [DATA_W-1:0]            Write_d,
    output logic                         busy,
    output logic                         xzr_drop
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int EW = REG_IDX_W + DATA_W;

    logic [NUM_SRC-1:0] full, empty, req, push, pop, rot;
    logic [EW-1:0]      head [NUM_SRC];
    logic [EW-1:0]      gnt_ent;
    logic [IW-1:0]      last_q, last_d, start, off, gnt_idx;
    logic               gnt_vld;
    logic               rdy_q;
    logic               xzr_q, xzr_d;
    logic               rw_q;
    logic [REG_IDX_W-1:0] wr_q;
    logic [DATA_W-1:0]  wd_q;
    int                 j, s;

    // Held low during reset and for the first edge after it.
    assign src_ready = {NUM_SRC{rdy_q}} & ~full;

    // XZR-targeted results are swallowed instead of enqueued.
    always_comb begin
        push  = '0;
        xzr_d = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i] && src_ready[i]) begin
                if (src_rd[i*REG_IDX_W +: REG_IDX_W] == SP_IDX &&
                    !src_to_sp[i])
                    xzr_d = 1'b1;
                else
                    push[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
        regwb_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (EW)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push_i  (push[g]),
            .data_i  ({src_rd[g*REG_IDX_W +: REG_IDX_W],
                       src_data[g*DATA_W +: DATA_W]}),
            .pop_i   (pop[g]),
            .full_o  (full[g]),
            .empty_o (empty[g]),
            .head_o  (head[g])
        );
    end

    assign req = ~empty;

    // Rotate requests so bit 0 is last+1, pick the lowest set bit,
    // then rotate the offset back into a source index.
    always_comb begin
        start = (last_q == IW'(NUM_SRC-1)) ? '0 : last_q + 1'b1;
        rot   = '0;
        j     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = int'(start) + k;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            rot[k] = req[IW'(j)];
        end
        gnt_vld = |rot;
        off     = '0;
        for (int k = NUM_SRC-1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        s = int'(start) + int'(off);
        if (s >= NUM_SRC) s = s - NUM_SRC;
        gnt_idx = IW'(s);
        pop     = '0;
        if (gnt_vld) pop[gnt_idx] = 1'b1;
        gnt_ent = head[gnt_idx];
        last_d  = gnt_vld ? gnt_idx : last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q  <= 1'b0;
            xzr_q  <= 1'b0;
            last_q <= IW'(NUM_SRC-1);
            rw_q   <= 1'b0;
            wr_q   <= '0;
            wd_q   <= '0;
        end else begin
            rdy_q  <= 1'b1;
            xzr_q  <= xzr_d;
            last_q <= last_d;
            rw_q   <= gnt_vld;
            // Index and data hold their value on idle cycles.
            if (gnt_vld) begin
                wr_q <= gnt_ent[EW-1 -: REG_IDX_W];
                wd_q <= gnt_ent[DATA_W-1:0];
            end
        end
    end

    assign RegWrite       = rw_q;
    assign Write_register = wr_q;
    assign Write_d        = wd_q;
    assign xzr_drop       = xzr_q;
    assign busy           = (req != '0) || rw_q;

endmodule
